tetris_game_ctrl: RTL and testbench

Game-level sequencer for the falling-piece datapath. It owns the gravity and move timebases, arbitrates the four active-low buttons into single-cycle move commands, and sequences each piece through spawn, fall, lock and line-clear phases. It keeps the score and detects game over. It sits between the button inputs, the piece-position register block and the board/collision logic, which supplies `stop`, `hit`, `clear_req` and `clear_done`.

---
 rtl/tetris_pkg.sv | 33 +++
 rtl/tetris_game_ctrl_if.sv | 35 +++
 rtl/tetris_game_ctrl_tick_div.sv | 40 ++++
 rtl/tetris_game_ctrl.sv | 191 +++++++++++++++++++
 tb/tb_tetris_game_ctrl.sv | 343 ++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/tetris_pkg.sv
// Shared definitions for the falling-piece game controller and the piece-position block.
// Holds the sequencer state encoding, the default timebase dividers and a saturating counter helper.
package tetris_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_SPAWN = 3'd1,
        ST_CHECK = 3'd2,
        ST_FALL  = 3'd3,
        ST_LOCK  = 3'd4,
        ST_CLEAR = 3'd5,
        ST_OVER  = 3'd6
    } state_t;

    localparam logic [31:0] GRAVITY_DIV_DEF   = 32'd12500000;
    localparam logic [31:0] MOVE_DIV_SLOW_DEF = 32'd4500000;
    localparam logic [31:0] MOVE_DIV_FAST_DEF = 32'd3000000;
    localparam logic [31:0] ROT_HOLD_DEF      = 32'd2000000;
    localparam logic [31:0] SPEEDUP_SCORE_DEF = 32'd4;
    localparam logic [9:0]  BLOCK_SIZE        = 10'd20;

    // The score sticks at all-ones instead of wrapping back to zero
    function automatic logic [31:0] sat_inc32(input logic [31:0] value);
        logic [31:0] result;
        if (value == 32'hFFFF_FFFF) begin
            result = value;
        end else begin
            result = value + 32'd1;
        end
        return result;
    endfunction

endpackage

// File: rtl/tetris_game_ctrl_if.sv
// Button, board-status and command bundle between the game sequencer and its environment.
// slave is the sequencer view; master is the button/board side.
interface tetris_game_ctrl_if;
    logic        up;
    logic        left;
    logic        down;
    logic        right;
    logic        stop;
    logic        hit;
    logic        clear_req;
    logic        clear_done;
    logic        spawn;
    logic        grav_step;
    logic        mv_left;
    logic        mv_right;
    logic        mv_down;
    logic        rotate;
    logic        lock;
    logic        clear_start;
    logic [31:0] score;
    logic        fast;
    logic        game_over;

    modport master (
        output up, left, down, right, stop, hit, clear_req, clear_done,
        input  spawn, grav_step, mv_left, mv_right, mv_down, rotate, lock,
        input  clear_start, score, fast, game_over
    );

    modport slave (
        input  up, left, down, right, stop, hit, clear_req, clear_done,
        output spawn, grav_step, mv_left, mv_right, mv_down, rotate, lock,
        output clear_start, score, fast, game_over
    );
endinterface

// File: rtl/tetris_game_ctrl_tick_div.sv
// Wrap counter producing a one-cycle tick every `limit` enabled cycles.
// The limit is sampled live, so a smaller value takes effect on the next comparison.
module tick_div #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             clr,
    input  logic [WIDTH-1:0] limit,
    output logic             tick
);
    localparam logic [WIDTH-1:0] ZERO = {WIDTH{1'b0}};
    localparam logic [WIDTH-1:0] ONE  = {{(WIDTH-1){1'b0}}, 1'b1};

    logic [WIDTH-1:0] count_r;

    // Terminal count uses >= so a count already past a lowered limit wraps at once
    always_comb begin
        tick = 1'b0;
        if (en && (count_r >= (limit - ONE))) begin
            tick = 1'b1;
        end else begin
            tick = 1'b0;
        end
    end

    // Count register: clear dominates, wrap to zero on the tick
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_r <= ZERO;
        end else if (clr) begin
            count_r <= ZERO;
        end else if (en) begin
            count_r <= tick ? ZERO : (count_r + ONE);
        end else begin
            count_r <= count_r;
        end
    end
endmodule

// File: rtl/tetris_game_ctrl.sv
// Game-level sequencer: spawn/fall/lock/clear phases, gravity and move timebases, button
// arbitration into single-cycle commands, score keeping and game-over detection.
module tetris_game_ctrl
    import tetris_pkg::*;
#(
    parameter logic [31:0] GRAVITY_DIV   = GRAVITY_DIV_DEF,
    parameter logic [31:0] MOVE_DIV_SLOW = MOVE_DIV_SLOW_DEF,
    parameter logic [31:0] MOVE_DIV_FAST = MOVE_DIV_FAST_DEF,
    parameter logic [31:0] SPEEDUP_SCORE = SPEEDUP_SCORE_DEF,
    parameter logic [31:0] ROT_HOLD      = ROT_HOLD_DEF
) (
    input  logic               iVGA_CLK,
    input  logic               reset,
    tetris_game_ctrl_if.slave  bus
);
    state_t      state_r, state_nxt_s;
    logic        in_fall_s, grav_tick_s, move_tick_s, rot_tick_s;
    logic [31:0] move_limit_s;
    logic        done_seen_r, done_seen_s;
    logic [31:0] score_r, score_s;
    logic        fast_r, game_over_r;
    logic        spawn_r, grav_step_r, mv_left_r, mv_right_r, mv_down_r;
    logic        rotate_r, lock_r, clear_start_r;
    logic        spawn_s, grav_step_s, mv_left_s, mv_right_s, mv_down_s;
    logic        rotate_s, lock_s, clear_start_s;

    assign in_fall_s = (state_r == ST_FALL);

    // Move rate follows the registered speed flag
    always_comb begin
        move_limit_s = MOVE_DIV_SLOW;
        if (fast_r) begin
            move_limit_s = MOVE_DIV_FAST;
        end else begin
            move_limit_s = MOVE_DIV_SLOW;
        end
    end

    tick_div #(.WIDTH(32)) u_grav (
        .clk(iVGA_CLK), .rst(reset), .en(in_fall_s), .clr(!in_fall_s),
        .limit(GRAVITY_DIV), .tick(grav_tick_s)
    );

    tick_div #(.WIDTH(32)) u_move (
        .clk(iVGA_CLK), .rst(reset), .en(in_fall_s), .clr(!in_fall_s),
        .limit(move_limit_s), .tick(move_tick_s)
    );

    // Rotate counter only accumulates an unbroken hold of `up` while falling
    tick_div #(.WIDTH(32)) u_rot (
        .clk(iVGA_CLK), .rst(reset), .en(in_fall_s && !bus.up),
        .clr(!in_fall_s || bus.up), .limit(ROT_HOLD), .tick(rot_tick_s)
    );

    // Next-state and next-pulse decode; pulses are registered alongside the state
    always_comb begin
        state_nxt_s   = state_r;
        done_seen_s   = done_seen_r;
        score_s       = score_r;
        spawn_s       = 1'b0;
        grav_step_s   = 1'b0;
        mv_left_s     = 1'b0;
        mv_right_s    = 1'b0;
        mv_down_s     = 1'b0;
        rotate_s      = 1'b0;
        lock_s        = 1'b0;
        clear_start_s = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (!bus.up) begin
                    state_nxt_s = ST_SPAWN;
                    spawn_s     = 1'b1;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_SPAWN: begin
                state_nxt_s = ST_CHECK;
            end
            ST_CHECK: begin
                if (bus.stop) begin
                    state_nxt_s = ST_OVER;
                end else begin
                    state_nxt_s = ST_FALL;
                end
            end
            ST_FALL: begin
                rotate_s = rot_tick_s;
                // Gravity wins a same-cycle collision; a blocked button never falls through
                if (grav_tick_s) begin
                    if (bus.stop) begin
                        state_nxt_s = ST_LOCK;
                        lock_s      = 1'b1;
                    end else begin
                        grav_step_s = 1'b1;
                    end
                end else if (move_tick_s) begin
                    if (!bus.left) begin
                        mv_left_s = !bus.hit;
                    end else if (!bus.down) begin
                        mv_down_s = !bus.stop;
                    end else if (!bus.right) begin
                        mv_right_s = !bus.hit;
                    end else begin
                        mv_left_s = 1'b0;
                    end
                end else begin
                    state_nxt_s = ST_FALL;
                end
            end
            ST_LOCK: begin
                done_seen_s = 1'b0;
                if (bus.clear_req) begin
                    state_nxt_s   = ST_CLEAR;
                    clear_start_s = 1'b1;
                end else begin
                    state_nxt_s = ST_SPAWN;
                    spawn_s     = 1'b1;
                end
            end
            ST_CLEAR: begin
                // One cycle after each removed row the board is re-examined
                if (done_seen_r) begin
                    done_seen_s = 1'b0;
                    if (bus.clear_req) begin
                        clear_start_s = 1'b1;
                    end else begin
                        state_nxt_s = ST_SPAWN;
                        spawn_s     = 1'b1;
                    end
                end else if (bus.clear_done) begin
                    score_s     = sat_inc32(score_r);
                    done_seen_s = 1'b1;
                end else begin
                    done_seen_s = 1'b0;
                end
            end
            ST_OVER: begin
                state_nxt_s = ST_OVER;
            end
            default: begin
                state_nxt_s = ST_IDLE;
            end
        endcase
    end

    // State, score and output registers
    always_ff @(posedge iVGA_CLK or posedge reset) begin
        if (reset) begin
            state_r       <= ST_IDLE;
            done_seen_r   <= 1'b0;
            score_r       <= 32'd0;
            fast_r        <= 1'b0;
            game_over_r   <= 1'b0;
            spawn_r       <= 1'b0;
            grav_step_r   <= 1'b0;
            mv_left_r     <= 1'b0;
            mv_right_r    <= 1'b0;
            mv_down_r     <= 1'b0;
            rotate_r      <= 1'b0;
            lock_r        <= 1'b0;
            clear_start_r <= 1'b0;
        end else begin
            state_r       <= state_nxt_s;
            done_seen_r   <= done_seen_s;
            score_r       <= score_s;
            fast_r        <= (score_r >= SPEEDUP_SCORE);
            game_over_r   <= (state_nxt_s == ST_OVER);
            spawn_r       <= spawn_s;
            grav_step_r   <= grav_step_s;
            mv_left_r     <= mv_left_s;
            mv_right_r    <= mv_right_s;
            mv_down_r     <= mv_down_s;
            rotate_r      <= rotate_s;
            lock_r        <= lock_s;
            clear_start_r <= clear_start_s;
        end
    end

    assign bus.spawn       = spawn_r;
    assign bus.grav_step   = grav_step_r;
    assign bus.mv_left     = mv_left_r;
    assign bus.mv_right    = mv_right_r;
    assign bus.mv_down     = mv_down_r;
    assign bus.rotate      = rotate_r;
    assign bus.lock        = lock_r;
    assign bus.clear_start = clear_start_r;
    assign bus.score       = score_r;
    assign bus.fast        = fast_r;
    assign bus.game_over   = game_over_r;
endmodule

// File: tb/tb_tetris_game_ctrl.sv
// Self-checking bench for tetris_game_ctrl with small dividers; the fall-phase reference
// derives each pulse from elapsed cycles since FALL entry and the button rules.
module tb_tetris_game_ctrl;
    localparam int GDIV = 16;
    localparam int MSLOW = 6;
    localparam int MFAST = 3;
    localparam int ROT = 5;

    logic iVGA_CLK = 1'b0;
    logic reset;
    int   n_checks = 0;
    int   n_pass = 0;
    int   fall_t = 0;
    int   held = 0;
    int   mdiv = MSLOW;
    logic [7:0] pv;

    always #5 iVGA_CLK = ~iVGA_CLK;

    tetris_game_ctrl_if bus ();

    tetris_game_ctrl #(
        .GRAVITY_DIV(32'd16), .MOVE_DIV_SLOW(32'd6), .MOVE_DIV_FAST(32'd3),
        .SPEEDUP_SCORE(32'd2), .ROT_HOLD(32'd5)
    ) dut (
        .iVGA_CLK(iVGA_CLK), .reset(reset), .bus(bus)
    );

    // bit order: spawn grav_step mv_left mv_right mv_down rotate lock clear_start
    assign pv = {bus.spawn, bus.grav_step, bus.mv_left, bus.mv_right,
                 bus.mv_down, bus.rotate, bus.lock, bus.clear_start};

    task automatic tick();
        @(posedge iVGA_CLK);
        #1;
    endtask

    task automatic idle_inputs();
        bus.up = 1'b1; bus.left = 1'b1; bus.down = 1'b1; bus.right = 1'b1;
        bus.stop = 1'b0; bus.hit = 1'b0; bus.clear_req = 1'b0; bus.clear_done = 1'b0;
    endtask

    function automatic logic [7:0] fall_model(input int t, input int md, input logic l,
                                              input logic d, input logic r, input logic h,
                                              input logic s, input logic rot);
        logic [7:0] v;
        v = 8'h00;
        if (t % GDIV == 0) begin
            if (s) v[1] = 1'b1;
            else   v[6] = 1'b1;
        end else if (t % md == 0) begin
            if (!l)      v[5] = !h;
            else if (!d) v[3] = !s;
            else if (!r) v[4] = !h;
        end
        v[2] = rot;
        return v;
    endfunction

    task automatic fall_step(input logic l, input logic d, input logic r, input logic u,
                             input logic h, input logic s, output logic [7:0] exp);
        logic rot;
        bus.left = l; bus.down = d; bus.right = r; bus.up = u; bus.hit = h; bus.stop = s;
        tick();
        fall_t++;
        if (!u) begin
            held++;
            rot = (held == ROT);
            if (rot) held = 0;
        end else begin
            held = 0;
            rot = 1'b0;
        end
        exp = fall_model(fall_t, mdiv, l, d, r, h, s, rot);
    endtask

    task automatic test_reset();
        reset = 1'b0;
        idle_inputs();
        #1 reset = 1'b1;
        tick(); tick();
        n_checks++;
        if (pv !== 8'h00) $display("FAIL reset_pulses: got %h expected 00", pv); else n_pass++;
        n_checks++;
        if (bus.score !== 32'd0 || bus.fast !== 1'b0 || bus.game_over !== 1'b0)
            $display("FAIL reset_status: got score=%0d fast=%b over=%b expected 0 0 0",
                     bus.score, bus.fast, bus.game_over);
        else n_pass++;
        #2 reset = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            n_checks++;
            if (pv !== 8'h00) $display("FAIL idle_hold: got %h expected 00", pv); else n_pass++;
        end
    endtask

    task automatic enter_fall(input string tag);
        bus.up = 1'b0;
        tick();
        bus.up = 1'b1;
        n_checks++;
        if (pv !== 8'h80) $display("FAIL %s_spawn: got %h expected 80", tag, pv); else n_pass++;
        tick();
        tick();
        n_checks++;
        if (pv !== 8'h00) $display("FAIL %s_check: got %h expected 00", tag, pv); else n_pass++;
        fall_t = 0;
        held = 0;
    endtask

    task automatic test_spawn_fall();
        logic [7:0] exp;
        int grav_cnt = 0;
        mdiv = MSLOW;
        enter_fall("first");
        for (int i = 0; i < 34; i++) begin
            fall_step(1'b1, 1'b1, 1'b1, 1'b1, 1'($urandom_range(0, 1)), 1'b0, exp);
            n_checks++;
            if (pv !== exp) $display("FAIL gravity t=%0d: got %h expected %h", fall_t, pv, exp);
            else n_pass++;
            if (pv[6]) grav_cnt++;
        end
        n_checks++;
        if (grav_cnt !== 2) $display("FAIL grav_count: got %0d expected 2", grav_cnt); else n_pass++;
    endtask

    task automatic test_moves();
        logic [7:0] exp;
        logic s;
        int lr_cnt = 0;
        int l_cnt = 0;
        int r_cnt = 0;
        for (int i = 0; i < 20; i++) begin
            fall_step(1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, exp);
            n_checks++;
            if (pv !== exp) $display("FAIL blocked t=%0d: got %h expected %h", fall_t, pv, exp);
            else n_pass++;
            if (pv[5] || pv[4]) lr_cnt++;
        end
        n_checks++;
        if (lr_cnt !== 0) $display("FAIL blocked_count: got %0d expected 0", lr_cnt); else n_pass++;
        for (int i = 0; i < 24; i++) begin
            fall_step(1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, exp);
            n_checks++;
            if (pv !== exp) $display("FAIL left_pri t=%0d: got %h expected %h", fall_t, pv, exp);
            else n_pass++;
            if (pv[5]) l_cnt++;
            if (pv[4]) r_cnt++;
        end
        n_checks++;
        if (l_cnt !== 4 || r_cnt !== 0)
            $display("FAIL left_count: got left=%0d right=%0d expected 4 0", l_cnt, r_cnt);
        else n_pass++;
        for (int i = 0; i < 40; i++) begin
            s = ((fall_t + 1) % GDIV == 0) ? 1'b0 : 1'($urandom_range(0, 1));
            bus.clear_done = 1'($urandom_range(0, 1));
            fall_step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                      1'($urandom_range(0, 1)), 1'b1, 1'($urandom_range(0, 1)), s, exp);
            n_checks++;
            if (pv !== exp) $display("FAIL random_move t=%0d: got %h expected %h", fall_t, pv, exp);
            else n_pass++;
        end
        bus.clear_done = 1'b0;
        n_checks++;
        if (bus.score !== 32'd0) $display("FAIL stray_clear_done: got score=%0d expected 0", bus.score);
        else n_pass++;
    endtask

    task automatic test_rotate();
        logic [7:0] exp;
        int rot_cnt = 0;
        int first_t = 0;
        int second_t = 0;
        for (int i = 0; i < 12; i++) begin
            fall_step(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, exp);
            n_checks++;
            if (pv !== exp) $display("FAIL rotate_hold t=%0d: got %h expected %h", fall_t, pv, exp);
            else n_pass++;
            if (pv[2]) begin
                rot_cnt++;
                if (rot_cnt == 1) first_t = fall_t; else second_t = fall_t;
            end
        end
        n_checks++;
        if (rot_cnt !== 2 || second_t - first_t !== ROT)
            $display("FAIL rotate_count: got %0d pulses spacing %0d expected 2 pulses spacing 5",
                     rot_cnt, second_t - first_t);
        else n_pass++;
        rot_cnt = 0;
        for (int i = 0; i < 11; i++) begin
            fall_step(1'b1, 1'b1, 1'b1, (i == 0 || i == 5) ? 1'b1 : 1'b0, 1'b0, 1'b0, exp);
            n_checks++;
            if (pv !== exp) $display("FAIL rotate_restart t=%0d: got %h expected %h", fall_t, pv, exp);
            else n_pass++;
            if (pv[2]) rot_cnt++;
        end
        n_checks++;
        if (rot_cnt !== 1 || pv[2] !== 1'b1)
            $display("FAIL rotate_restart_count: got %0d last=%b expected 1 1", rot_cnt, pv[2]);
        else n_pass++;
    endtask

    task automatic test_lock_clear();
        logic [7:0] exp;
        int l_cnt = 0;
        for (int i = 0; i < GDIV && ((fall_t + 1) % GDIV) != 0; i++) begin
            fall_step(1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, exp);
            n_checks++;
            if (pv !== exp) $display("FAIL pre_lock t=%0d: got %h expected %h", fall_t, pv, exp);
            else n_pass++;
        end
        bus.clear_req = 1'b1;
        fall_step(1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, exp);
        n_checks++;
        if (pv !== 8'h02) $display("FAIL lock: got %h expected 02", pv); else n_pass++;
        bus.stop = 1'b0;
        tick();
        n_checks++;
        if (pv !== 8'h01) $display("FAIL clear_start: got %h expected 01", pv); else n_pass++;
        tick(); tick();
        n_checks++;
        if (pv !== 8'h00) $display("FAIL clear_wait: got %h expected 00", pv); else n_pass++;
        bus.clear_done = 1'b1;
        tick();
        bus.clear_done = 1'b0;
        n_checks++;
        if (bus.score !== 32'd1) $display("FAIL score_1: got %0d expected 1", bus.score); else n_pass++;
        tick();
        n_checks++;
        if (pv !== 8'h01 || bus.fast !== 1'b0)
            $display("FAIL clear_again: got %h fast=%b expected 01 fast=0", pv, bus.fast);
        else n_pass++;
        tick();
        bus.clear_done = 1'b1;
        bus.clear_req = 1'b0;
        tick();
        bus.clear_done = 1'b0;
        n_checks++;
        if (bus.score !== 32'd2) $display("FAIL score_2: got %0d expected 2", bus.score); else n_pass++;
        tick();
        n_checks++;
        if (pv !== 8'h80 || bus.fast !== 1'b1)
            $display("FAIL spawn_after_clear: got %h fast=%b expected 80 fast=1", pv, bus.fast);
        else n_pass++;
        tick(); tick();
        fall_t = 0;
        held = 0;
        mdiv = MFAST;
        for (int i = 0; i < 20; i++) begin
            fall_step(1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, exp);
            n_checks++;
            if (pv !== exp) $display("FAIL fast_move t=%0d: got %h expected %h", fall_t, pv, exp);
            else n_pass++;
            if (pv[5]) l_cnt++;
        end
        n_checks++;
        if (l_cnt !== 6) $display("FAIL fast_count: got %0d expected 6", l_cnt); else n_pass++;
    endtask

    task automatic test_game_over();
        logic [7:0] exp;
        for (int i = 0; i < GDIV && ((fall_t + 1) % GDIV) != 0; i++) begin
            fall_step(1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, exp);
        end
        fall_step(1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, exp);
        n_checks++;
        if (pv !== 8'h02) $display("FAIL lock_no_clear: got %h expected 02", pv); else n_pass++;
        tick();
        n_checks++;
        if (pv !== 8'h80) $display("FAIL respawn: got %h expected 80", pv); else n_pass++;
        tick();
        tick();
        n_checks++;
        if (pv !== 8'h00 || bus.game_over !== 1'b1)
            $display("FAIL game_over: got %h over=%b expected 00 over=1", pv, bus.game_over);
        else n_pass++;
        for (int i = 0; i < 30; i++) begin
            {bus.up, bus.left, bus.down, bus.right} = 4'($urandom_range(0, 15));
            {bus.stop, bus.hit, bus.clear_req, bus.clear_done} = 4'($urandom_range(0, 15));
            tick();
            n_checks++;
            if (pv !== 8'h00 || bus.game_over !== 1'b1 || bus.score !== 32'd2)
                $display("FAIL over_hold: got %h over=%b score=%0d expected 00 over=1 score=2",
                         pv, bus.game_over, bus.score);
            else n_pass++;
        end
        idle_inputs();
        #2 reset = 1'b1;
        #1;
        n_checks++;
        if (bus.score !== 32'd0 || bus.game_over !== 1'b0 || bus.fast !== 1'b0)
            $display("FAIL over_reset: got score=%0d over=%b fast=%b expected 0 0 0",
                     bus.score, bus.game_over, bus.fast);
        else n_pass++;
        #2 reset = 1'b0;
        tick(); tick();
        n_checks++;
        if (pv !== 8'h00) $display("FAIL idle_after_reset: got %h expected 00", pv); else n_pass++;
    endtask

    task automatic test_reset_mid_clear();
        logic [7:0] exp;
        mdiv = MSLOW;
        enter_fall("second");
        for (int i = 0; i < GDIV - 1; i++) begin
            fall_step(1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, exp);
        end
        bus.clear_req = 1'b1;
        fall_step(1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, exp);
        bus.stop = 1'b0;
        tick();
        bus.clear_done = 1'b1;
        tick();
        bus.clear_done = 1'b0;
        tick();
        n_checks++;
        if (pv !== 8'h01 || bus.score !== 32'd1)
            $display("FAIL pre_abort: got %h score=%0d expected 01 score=1", pv, bus.score);
        else n_pass++;
        #2 reset = 1'b1;
        #1;
        n_checks++;
        if (pv !== 8'h00 || bus.score !== 32'd0 || bus.game_over !== 1'b0 || bus.fast !== 1'b0)
            $display("FAIL async_abort: got %h score=%0d over=%b fast=%b expected 00 0 0 0",
                     pv, bus.score, bus.game_over, bus.fast);
        else n_pass++;
        idle_inputs();
        #2 reset = 1'b0;
        tick();
    endtask

    initial begin
        test_reset();
        test_spawn_fall();
        test_moves();
        test_rotate();
        test_lock_clear();
        test_game_over();
        test_reset_mid_clear();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
